// File: rtl/m_prog_loader.sv
// UART (8N1) program loader: header word count N, then N LE words written to instruction memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module m_prog_loader #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_rxd,
    output logic        w_we,
    output logic [11:0] w_addr,
    output logic [31:0] w_data,
    output logic        w_proc_ce,
    output logic        w_busy,
    output logic        w_err
);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] ST_WAIT_HDR = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_ERR      = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK      = 3'd2;
    localparam logic [2:0] ST_AFTER_LOAD = ST_CHECK;
`else
    localparam logic [2:0] ST_AFTER_LOAD = ST_DONE;
`endif

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rxd_s1_q, rxd_s2_q, rxd_s3_q;
    logic [1:0]  rx_st_q, rx_st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        rx_vld, rx_start_ok, rx_en;

    logic [2:0]  st_q, st_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] word_q, word_d;
    logic [31:0] word_nxt;
    logic [12:0] n_q, n_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        busy_q, busy_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    // The receiver is held idle once the load has finished either way.
    assign rx_en = (st_q != ST_DONE) && (st_q != ST_ERR);

    always_comb begin
        rx_st_d     = rx_st_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        rx_vld      = 1'b0;
        rx_start_ok = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (rxd_s3_q && !rxd_s2_q) begin
                    rx_st_d = RX_START;
                    cnt_d   = 16'd0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    bit_d = 3'd0;
                    if (rxd_s2_q) begin
                        rx_st_d = RX_IDLE;
                    end else begin
                        rx_st_d     = RX_DATA;
                        rx_start_ok = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    sh_d  = {rxd_s2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_st_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    rx_vld  = 1'b1;
                    rx_st_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
        if (!rx_en) rx_st_d = RX_IDLE;
    end

    assign word_nxt = {sh_q, word_q};

    always_comb begin
        st_d   = st_q;
        byte_d = byte_q;
        word_d = word_q;
        n_d    = n_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        busy_d = busy_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_d  = xor_q;
`endif
        if (st_q == ST_WAIT_HDR && rx_start_ok) busy_d = 1'b1;
        // Address saturates at the top of memory so N=4096 does not wrap to 0.
        if (we_q) begin
            if (addr_q != 12'hFFF) addr_d = addr_q + 12'd1;
            if ({1'b0, addr_q} == n_q - 13'd1) st_d = ST_AFTER_LOAD;
        end
        if (rx_vld && rx_en) begin
            if (!rxd_s2_q) begin
                st_d = ST_ERR;
            end else begin
                case (st_q)
                    ST_WAIT_HDR, ST_LOAD: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        xor_d  = xor_q ^ sh_q;
`endif
                        byte_d = byte_q + 2'd1;
                        case (byte_q)
                            2'd0:    word_d[7:0]   = sh_q;
                            2'd1:    word_d[15:8]  = sh_q;
                            2'd2:    word_d[23:16] = sh_q;
                            default: ;
                        endcase
                        if (byte_q == 2'd3) begin
                            if (st_q == ST_WAIT_HDR) begin
                                if (word_nxt > 32'd4096) begin
                                    st_d = ST_ERR;
                                end else if (word_nxt == 32'd0) begin
                                    st_d = ST_AFTER_LOAD;
                                end else begin
                                    n_d  = word_nxt[12:0];
                                    st_d = ST_LOAD;
                                end
                            end else begin
                                we_d   = 1'b1;
                                data_d = word_nxt;
                            end
                        end
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    ST_CHECK: st_d = (sh_q == xor_q) ? ST_DONE : ST_ERR;
`endif
                    default: ;
                endcase
            end
        end
        if (st_d == ST_DONE || st_d == ST_ERR) busy_d = 1'b0;
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
            rx_st_q  <= RX_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            sh_q     <= 8'd0;
            st_q     <= ST_WAIT_HDR;
            byte_q   <= 2'd0;
            word_q   <= 24'd0;
            n_q      <= 13'd0;
            we_q     <= 1'b0;
            addr_q   <= 12'd0;
            data_q   <= 32'd0;
            busy_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q    <= 8'd0;
`endif
        end else begin
            rxd_s1_q <= w_rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
            rx_st_q  <= rx_st_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            st_q     <= st_d;
            byte_q   <= byte_d;
            word_q   <= word_d;
            n_q      <= n_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    assign w_we      = we_q;
    assign w_addr    = addr_q;
    assign w_data    = data_q;
    assign w_proc_ce = (st_q == ST_DONE);
    assign w_busy    = busy_q;
    assign w_err     = (st_q == ST_ERR);

endmodule

// File: tb/tb_m_prog_loader.sv
// Bench for m_prog_loader: directed and random UART loads, scoreboarded memory writes.
module tb_m_prog_loader;
    localparam int CPB = 4;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_rxd = 1'b1;
    logic        w_we;
    logic [11:0] w_addr;
    logic [31:0] w_data;
    logic        w_proc_ce;
    logic        w_busy;
    logic        w_err;

    m_prog_loader #(.CLKS_PER_BIT(CPB)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_rxd(w_rxd), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data), .w_proc_ce(w_proc_ce),
        .w_busy(w_busy), .w_err(w_err)
    );

    always #5 w_clk = ~w_clk;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  tx_q[$];
    int          bad_idx;
    int          errs = 0;
    int          checks = 0;
    int          n_wr;
    logic [31:0] last_word;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge w_clk) begin
        if (w_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", w_addr, w_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", {20'd0, w_addr}, {20'd0, mon_e.a});
                chk("write_data", w_data, mon_e.d);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge w_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        w_rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            w_rxd = b[i];
            tick(CPB);
        end
        w_rxd = stop;
        tick(CPB);
        w_rxd = 1'b1;
        tick($urandom_range(0, 3));
    endtask

    task automatic do_reset();
        w_rst_n = 1'b0;
        w_rxd   = 1'b1;
        tick(3);
        w_rst_n = 1'b1;
        tick(2);
        exp_q.delete();
    endtask

    task automatic start_test();
        tx_q.delete();
        bad_idx = -1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic add_ck(input logic corrupt);
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        foreach (tx_q[i]) x ^= tx_q[i];
        tx_q.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
        if (corrupt) bad_idx = bad_idx;
`endif
    endtask

    // Reference: parse the byte stream as count + LE words (+ checksum) and predict the outcome.
    task automatic model(output logic done, output logic err);
        logic [31:0] n;
        int          base;
        done = 1'b0;
        err  = 1'b0;
        n_wr = 0;
        last_word = 32'd0;
        if (bad_idx >= 0 && bad_idx < 4) begin err = 1'b1; return; end
        if (tx_q.size() < 4) return;
        n = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
        if (n > 32'd4096) begin err = 1'b1; return; end
        for (int i = 0; i < int'(n); i++) begin
            base = 4 + 4 * i;
            if (bad_idx >= base && bad_idx < base + 4) begin err = 1'b1; return; end
            if (base + 4 > tx_q.size()) return;
            last_word = {tx_q[base+3], tx_q[base+2], tx_q[base+1], tx_q[base]};
            exp_q.push_back('{a: 12'(i), d: last_word});
            n_wr++;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            base = 4 + 4 * int'(n);
            if (bad_idx == base) begin err = 1'b1; return; end
            if (base >= tx_q.size()) return;
            x = 8'd0;
            for (int i = 0; i < base; i++) x ^= tx_q[i];
            if (tx_q[base] == x) done = 1'b1;
            else err = 1'b1;
        end
`else
        done = 1'b1;
`endif
    endtask

    task automatic run_stream(input string nm);
        logic done, err;
        model(done, err);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], i != bad_idx);
            if (i == bad_idx) break;
        end
        tick(30);
        chk({nm, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_proc_ce"}, {31'd0, w_proc_ce}, {31'd0, done});
        chk({nm, "_err"}, {31'd0, w_err}, {31'd0, err});
        chk({nm, "_busy"}, {31'd0, w_busy}, {31'd0, !done && !err && tx_q.size() > 0});
        chk({nm, "_addr"}, {20'd0, w_addr}, 32'(n_wr));
        chk({nm, "_data"}, w_data, last_word);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_we"}, {31'd0, w_we}, 32'd0);
        chk({nm, "_addr"}, {20'd0, w_addr}, 32'd0);
        chk({nm, "_data"}, w_data, 32'd0);
        chk({nm, "_proc_ce"}, {31'd0, w_proc_ce}, 32'd0);
        chk({nm, "_busy"}, {31'd0, w_busy}, 32'd0);
        chk({nm, "_err"}, {31'd0, w_err}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, kind;
        do_reset();
        chk_idle("reset");

        start_test();
        push_word(32'd2); push_word(32'h0000_0013); push_word(32'h000f_0033); add_ck(1'b0);
        run_stream("two_words");

        do_reset();
        start_test();
        push_word(32'd0); add_ck(1'b0);
        run_stream("n_zero");

        do_reset();
        start_test();
        push_word(32'd4097);
        run_stream("n_4097");

        do_reset();
        start_test();
        push_word(32'd1); push_word(32'hDEAD_BEEF); add_ck(1'b0);
        bad_idx = 5;
        run_stream("bad_stop");

        do_reset();
        start_test();
        push_word(32'd4096); push_word(32'h1234_5678);
        run_stream("n_4096_start");

        do_reset();
        tick(5);
        w_rxd = 1'b0;
        tick(1);
        w_rxd = 1'b1;
        tick(20);
        chk_idle("glitch");
        start_test();
        push_word(32'd1); push_word(32'hA5A5_0F0F); add_ck(1'b0);
        run_stream("after_glitch");

        do_reset();
        start_test();
        push_word(32'd3); push_word(32'h1111_1111); push_word(32'h2222_2222);
        run_stream("partial_load");
        send_byte(8'h33, 1'b1);
        do_reset();
        chk_idle("mid_load_reset");
        start_test();
        push_word(32'd1); push_word(32'h0BAD_F00D); add_ck(1'b0);
        run_stream("reload");

`ifdef PROG_LOADER_CHECKSUM_EN
        do_reset();
        start_test();
        push_word(32'd1); push_word(32'hCAFE_0001); add_ck(1'b1);
        run_stream("bad_checksum");
`endif

        for (int it = 0; it < 10; it++) begin
            do_reset();
            start_test();
            n    = $urandom_range(0, 4);
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                push_word(32'd4097 + 32'($urandom_range(0, 1000)));
            end else begin
                push_word(32'(n));
                for (int w = 0; w < n; w++) push_word($urandom);
                add_ck(kind == 2);
                if (kind == 1) bad_idx = $urandom_range(0, tx_q.size() - 1);
            end
            run_stream($sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/m_prog_loader.md
M_PROG_LOADER -- requirements
Module: m_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 100, meaning w_clk cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have port w_clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port w_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port w_rxd  input  1  asynchronous UART serial input; idles high.
REQ-005 SHALL have port w_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-006 SHALL have port w_addr  output  12  instruction-memory word address.
REQ-007 SHALL have port w_data  output  32  instruction word to write.
REQ-008 SHALL have port w_proc_ce  output  1  processor clock enable; high only after a successful load.
REQ-009 SHALL have port w_busy  output  1  high while a load is in progress.
REQ-010 SHALL have port w_err  output  1  sticky error flag.

Function
REQ-011 SHALL pass w_rxd through a two-flop synchronizer before any use.
REQ-012 SHALL run the UART receiver as 8N1, LSB first: IDLE -> START on a synchronized falling edge; sample at CLKS_PER_BIT/2; if the sample is high, return to IDLE (glitch reject); otherwise take 8 data samples and 1 stop sample, spaced CLKS_PER_BIT apart.
REQ-013 SHALL treat a stop-bit sample of 0 as a framing error: set w_err and enter ERR.
REQ-014 SHALL interpret the byte stream as a 4-byte little-endian word count N followed by N little-endian 32-bit words.
REQ-015 SHALL run the top FSM through the states WAIT_HDR, LOAD, (CHECK), DONE and ERR; it SHALL leave reset in WAIT_HDR.
REQ-016 SHALL raise w_busy from the first header start bit until DONE or ERR is reached.
REQ-017 SHALL, when N > 4096, set w_err, enter ERR and issue no writes.
REQ-018 SHALL, when N == 0, go from the header directly to DONE (or CHECK) with no writes.
REQ-019 SHALL assert w_we for exactly one cycle, on the cycle after the stop-bit sample of each word's 4th byte, with w_data holding the assembled word and w_addr = word index (0 for the first word).
REQ-020 SHALL increment w_addr the cycle after each w_we and hold it otherwise; for N=4096 the last write is at address 4095, and there is no wrap.
REQ-021 SHALL hold w_data stable from w_we until the next word completes.
REQ-022 SHALL, in DONE, hold w_proc_ce high and ignore further w_rxd activity until reset.
REQ-023 SHALL keep w_proc_ce low in every state other than DONE.
REQ-024 SHALL, in ERR, hold w_err high and w_proc_ce low, accept no further writes and ignore w_rxd until reset.

Reset
REQ-025 SHALL, with w_rst_n low at a posedge, force: w_we=0, w_addr=0, w_data=0, w_proc_ce=0, w_busy=0, w_err=0, FSM=WAIT_HDR, receiver=IDLE, byte/word counters=0, checksum=0.
REQ-026 SHALL apply reset in any state, including mid-byte and mid-load; the partial word SHALL be discarded and no w_we SHALL be issued in the reset cycle.
REQ-027 SHALL require a complete new header after reset; previously written memory contents are not tracked.

Configuration
REQ-028 SHALL support the macro PROG_LOADER_CHECKSUM_EN.
REQ-029 SHALL, when PROG_LOADER_CHECKSUM_EN is defined, XOR all header and payload bytes, receive one trailing checksum byte in state CHECK, and enter DONE only if the trailing byte equals the XOR; otherwise it SHALL set w_err and enter ERR. Words already written remain written.
REQ-030 SHALL, when PROG_LOADER_CHECKSUM_EN is undefined, omit state CHECK entirely and enter DONE on the cycle after the last w_we, or directly after the header when N=0.

Verification (bench CLKS_PER_BIT=4)
REQ-031 SHALL cover: header 02 00 00 00, words 0x00000013 and 0x000f0033 -> w_we pulses at addr 0 (data 0x00000013) and addr 1 (data 0x000f0033); w_proc_ce=1, w_busy=0, w_err=0.
REQ-032 SHALL cover: header 00 00 00 00 -> no w_we; w_proc_ce=1 (without the checksum macro).
REQ-033 SHALL cover: header 01 10 00 00 (N=4097) -> w_err=1, no w_we, w_proc_ce=0.
REQ-034 SHALL cover: stop bit driven 0 on the 6th byte -> w_err=1; only the N-independent state is reached; no write for word 0; w_proc_ce=0.
REQ-035 SHALL cover: a 1-cycle low glitch on idle w_rxd -> no byte received; FSM stays in WAIT_HDR.
REQ-036 SHALL cover: w_rst_n pulsed low after 2 of 3 words, then a full 1-word load -> its write is at addr 0; w_proc_ce=1; and, with the checksum macro defined, a wrong checksum byte -> w_err=1, w_proc_ce=0.
